// File: rtl/ctrl_pkg.sv
// Shared types and constants for the Othello game controller.
package ctrl_pkg;

    localparam int BOARD_W = 128;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        AI_CALC     = 3'd1,
        AI_PLACE    = 3'd2,
        WAIT_PLAYER = 3'd3,
        GAMEOVER    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        AI    = 2'b01,
        HUMAN = 2'b10
    } cell_t;

    localparam logic [1:0] MODE_EASY   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_HARD   = 2'd2;
    localparam logic [1:0] MODE_2P     = 2'd3;

    // True when the board is full once cell idx has been filled.
    function automatic logic full_with(input logic [BOARD_W-1:0] board, input logic [5:0] idx);
        logic full;
        full = 1'b1;
        for (int unsigned i = 0; i < 64; i++) begin
            if (board[{i[5:0], 1'b0} +: 2] == EMPTY && i[5:0] != idx)
                full = 1'b0;
        end
        return full;
    endfunction

endpackage

// File: rtl/ctrl_ai_scan.sv
// Raster-order move scanner: one cell per cycle, neighbour scoring per mode,
// max tracking with lowest-index tie break; empty board yields (3,3).
module ctrl_ai_scan
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BOARD_W-1:0] board,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic               abort,
    output logic [2:0]         best_row,
    output logic [2:0]         best_col,
    output logic               done
);

    logic [5:0] idx;
    logic       busy;
    logic       best_valid;
    logic [5:0] best_idx;
    logic [3:0] best_score;

    logic [3:0] cnt_ai;
    logic [3:0] cnt_hu;
    logic [3:0] score;
    logic [3:0] nr;
    logic [3:0] nc;
    logic [1:0] nb;
    logic       cur_empty;
    logic       take;
    logic [5:0] final_idx;

    // Neighbour coordinates use a 4-bit wrap so both -1 and 8 land with bit 3 set.
    always_comb begin
        cnt_ai = '0;
        cnt_hu = '0;
        nr     = '0;
        nc     = '0;
        nb     = '0;
        for (int unsigned d = 0; d < 9; d++) begin
            if (d != 4) begin
                nr = {1'b0, idx[5:3]} + 4'(d / 3) - 4'd1;
                nc = {1'b0, idx[2:0]} + 4'(d % 3) - 4'd1;
                if (!nr[3] && !nc[3]) begin
                    nb = board[{nr[2:0], nc[2:0], 1'b0} +: 2];
                    if (nb == AI)
                        cnt_ai = cnt_ai + 4'd1;
                    if (nb == HUMAN)
                        cnt_hu = cnt_hu + 4'd1;
                end
            end
        end

        case (mode)
            MODE_EASY:   score = '0;
            MODE_NORMAL: score = cnt_ai + cnt_hu;
            default:     score = cnt_ai + {cnt_hu[2:0], 1'b0};
        endcase

        cur_empty = board[{idx, 1'b0} +: 2] == EMPTY;
        take      = cur_empty && (!best_valid || score > best_score);
        final_idx = take ? idx : best_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            busy       <= 1'b0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
            best_row   <= '0;
            best_col   <= '0;
            done       <= 1'b0;
        end else if (start) begin
            idx        <= '0;
            busy       <= 1'b1;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
            done       <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (take) begin
                    best_valid <= 1'b1;
                    best_idx   <= idx;
                    best_score <= score;
                end
                idx <= idx + 6'd1;
                if (idx == 6'd63) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (board == '0)
                        {best_row, best_col} <= 6'd27;
                    else
                        {best_row, best_col} <= final_idx;
                end
            end
        end
    end

endmodule

// File: rtl/othello_ctrl.sv
// Othello game controller: FSM, board registers and one-step undo history.
// Define CTRL_UNDO_EN to compile in undo history and i_prestep handling.
module othello_ctrl
    import ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_mode,
    input  logic               i_start,
    input  logic               i_surrender,
    input  logic               i_prestep,
    input  logic [2:0]         i_row,
    input  logic [2:0]         i_col,
    input  logic               i_player_done,
    output logic [BOARD_W-1:0] o_board,
    output logic [2:0]         o_row,
    output logic [2:0]         o_col,
    output logic               o_aidone,
    output logic [2:0]         o_state
);

    state_t     state;
    state_t     state_n;
    logic [1:0] mode_q;
    logic       turn_hu;
    logic       two_p;

    logic [2:0] scan_row;
    logic [2:0] scan_col;
    logic       scan_done;
    logic       scan_start;
    logic       scan_abort;

    logic       clr_board;
    logic       wr_en;
    logic [5:0] wr_idx;
    cell_t      wr_val;
    logic       aidone_n;
    logic       turn_toggle;
    logic       undo_en;
    logic       undo_ok;
    logic [5:0] player_idx;
    logic [5:0] ai_idx;
    logic       player_empty;

    assign two_p        = mode_q == MODE_2P;
    assign player_idx   = {i_row, i_col};
    assign ai_idx       = {scan_row, scan_col};
    assign player_empty = o_board[{player_idx, 1'b0} +: 2] == EMPTY;
    assign scan_abort   = state != AI_CALC || i_surrender;
    assign o_state      = state;

`ifdef CTRL_UNDO_EN
    logic [5:0] hist_last;
    logic [5:0] hist_prev;
    logic [1:0] hist_cnt;

    // 1P undo removes a human+AI pair, so it needs two recorded placements.
    assign undo_ok = i_prestep && (two_p ? hist_cnt != 2'd0 : hist_cnt == 2'd2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hist_last <= '0;
            hist_prev <= '0;
            hist_cnt  <= '0;
        end else if (clr_board) begin
            hist_cnt <= '0;
        end else if (wr_en) begin
            hist_prev <= hist_last;
            hist_last <= wr_idx;
            if (hist_cnt != 2'd2)
                hist_cnt <= hist_cnt + 2'd1;
        end else if (undo_en) begin
            hist_cnt <= '0;
        end
    end
`else
    logic unused_undo;
    assign undo_ok     = 1'b0;
    assign unused_undo = i_prestep ^ undo_en;
`endif

    ctrl_ai_scan u_scan (
        .clk      (i_clk),
        .rst      (i_rst),
        .board    (o_board),
        .mode     (mode_q),
        .start    (scan_start),
        .abort    (scan_abort),
        .best_row (scan_row),
        .best_col (scan_col),
        .done     (scan_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n     = state;
        clr_board   = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_val      = EMPTY;
        aidone_n    = 1'b0;
        scan_start  = 1'b0;
        turn_toggle = 1'b0;
        undo_en     = 1'b0;

        if (i_start) begin
            clr_board = 1'b1;
            if (i_mode == MODE_2P) begin
                state_n = WAIT_PLAYER;
            end else begin
                state_n    = AI_CALC;
                scan_start = 1'b1;
            end
        end else begin
            case (state)
                AI_CALC: begin
                    if (i_surrender)
                        state_n = GAMEOVER;
                    else if (scan_done)
                        state_n = AI_PLACE;
                end
                AI_PLACE: begin
                    if (i_surrender) begin
                        state_n = GAMEOVER;
                    end else begin
                        wr_en    = 1'b1;
                        wr_idx   = ai_idx;
                        wr_val   = AI;
                        aidone_n = 1'b1;
                        state_n  = full_with(o_board, ai_idx) ? GAMEOVER : WAIT_PLAYER;
                    end
                end
                WAIT_PLAYER: begin
                    if (i_surrender) begin
                        state_n = GAMEOVER;
                    end else if (undo_ok) begin
                        undo_en     = 1'b1;
                        turn_toggle = two_p;
                    end else if (i_player_done && player_empty) begin
                        wr_en  = 1'b1;
                        wr_idx = player_idx;
                        wr_val = (two_p && !turn_hu) ? AI : HUMAN;
                        if (full_with(o_board, player_idx)) begin
                            state_n = GAMEOVER;
                        end else if (two_p) begin
                            turn_toggle = 1'b1;
                        end else begin
                            state_n    = AI_CALC;
                            scan_start = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_board <= '0;
        end else if (clr_board) begin
            o_board <= '0;
        end else begin
            if (wr_en)
                o_board[{wr_idx, 1'b0} +: 2] <= wr_val;
`ifdef CTRL_UNDO_EN
            if (undo_en) begin
                o_board[{hist_last, 1'b0} +: 2] <= EMPTY;
                if (!two_p)
                    o_board[{hist_prev, 1'b0} +: 2] <= EMPTY;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q   <= '0;
            turn_hu  <= 1'b0;
            o_row    <= '0;
            o_col    <= '0;
            o_aidone <= 1'b0;
        end else begin
            o_aidone <= aidone_n;
            if (i_start) begin
                mode_q  <= i_mode;
                turn_hu <= 1'b0;
            end else if (turn_toggle) begin
                turn_hu <= ~turn_hu;
            end
            if (aidone_n) begin
                o_row <= scan_row;
                o_col <= scan_col;
            end
        end
    end

endmodule

// File: tb/tb_othello_ctrl.sv
// Self-checking bench for othello_ctrl: cycle-level game model plus directed scenarios.
module tb_othello_ctrl;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic         start;
    logic         surrender;
    logic         prestep;
    logic [2:0]   row;
    logic [2:0]   col;
    logic         player_done;
    logic [127:0] o_board;
    logic [2:0]   o_row;
    logic [2:0]   o_col;
    logic         o_aidone;
    logic [2:0]   o_state;

    int n_checks = 0;
    int n_fail   = 0;

    othello_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mode        (mode),
        .i_start       (start),
        .i_surrender   (surrender),
        .i_prestep     (prestep),
        .i_row         (row),
        .i_col         (col),
        .i_player_done (player_done),
        .o_board       (o_board),
        .o_row         (o_row),
        .o_col         (o_col),
        .o_aidone      (o_aidone),
        .o_state       (o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    logic [1:0] m_board [64];
    int         m_state, m_mode, m_timer, m_pick, m_row, m_col;
    bit         m_turn, m_aidone;
    int         m_hist [$];

    function automatic bit m_full();
        for (int i = 0; i < 64; i++)
            if (m_board[i] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [127:0] m_pack();
        logic [127:0] v;
        for (int i = 0; i < 64; i++) v[2*i +: 2] = m_board[i];
        return v;
    endfunction

    function automatic int ai_pick();
        int  best, best_s, a, b, s, r, c;
        bit  any;
        any = 0;
        for (int i = 0; i < 64; i++) if (m_board[i] != 2'b00) any = 1;
        if (!any) return 27;
        best = -1;
        best_s = -1;
        for (int i = 0; i < 64; i++) begin
            if (m_board[i] == 2'b00) begin
                r = i / 8; c = i % 8; a = 0; b = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8) begin
                            if (m_board[(r+dr)*8 + c+dc] == 2'b01) a++;
                            if (m_board[(r+dr)*8 + c+dc] == 2'b10) b++;
                        end
                s = (m_mode == 0) ? 0 : (m_mode == 1) ? a + b : (a + 2*b) % 16;
                if (s > best_s) begin best = i; best_s = s; end
            end
        end
        return best;
    endfunction

    function automatic void m_place(input int i, input logic [1:0] v);
        m_board[i] = v;
        m_hist.push_back(i);
    endfunction

    function automatic void m_enter_calc();
        m_state = 1;
        m_timer = 0;
        m_pick  = ai_pick();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) m_board[i] = 2'b00;
            m_state = 0; m_mode = 0; m_timer = 0; m_pick = 0;
            m_row = 0; m_col = 0; m_turn = 0; m_aidone = 0;
            m_hist.delete();
        end else begin
            m_aidone = 0;
            if (start) begin
                for (int i = 0; i < 64; i++) m_board[i] = 2'b00;
                m_hist.delete();
                m_mode = int'(mode);
                m_turn = 0;
                if (m_mode == 3) m_state = 3;
                else m_enter_calc();
            end else begin
                case (m_state)
                    1: if (surrender) m_state = 4;
                       else begin
                           m_timer++;
                           if (m_timer == 65) m_state = 2;
                       end
                    2: if (surrender) m_state = 4;
                       else begin
                           m_place(m_pick, 2'b01);
                           m_row = m_pick / 8;
                           m_col = m_pick % 8;
                           m_aidone = 1;
                           m_state = m_full() ? 4 : 3;
                       end
                    3: begin
                        bit undo_done;
                        int p;
                        undo_done = 0;
                        p = int'(row) * 8 + int'(col);
                        if (surrender) begin
                            m_state = 4;
                        end else begin
`ifdef CTRL_UNDO_EN
                            if (prestep) begin
                                if (m_mode == 3 && m_hist.size() >= 1) begin
                                    m_board[m_hist[$]] = 2'b00;
                                    m_turn = !m_turn;
                                    m_hist.delete();
                                    undo_done = 1;
                                end else if (m_mode != 3 && m_hist.size() >= 2) begin
                                    m_board[m_hist[$]] = 2'b00;
                                    m_board[m_hist[$-1]] = 2'b00;
                                    m_hist.delete();
                                    undo_done = 1;
                                end
                            end
`endif
                            if (!undo_done && player_done && m_board[p] == 2'b00) begin
                                m_place(p, (m_mode == 3 && !m_turn) ? 2'b01 : 2'b10);
                                if (m_full()) m_state = 4;
                                else if (m_mode == 3) m_turn = !m_turn;
                                else m_enter_calc();
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("state",  o_state,  m_state);
            check("aidone", o_aidone, m_aidone);
            check("row",    o_row,    m_row);
            check("col",    o_col,    m_col);
            check("board",  o_board,  m_pack());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] md);
        mode = md; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic player(input int r, input int c);
        row = 3'(r); col = 3'(c); player_done = 1'b1;
        tick();
        player_done = 1'b0;
    endtask

    task automatic pulse_prestep();
        prestep = 1'b1;
        tick();
        prestep = 1'b0;
    endtask

    task automatic wait_aidone(input string name);
        int k;
        k = 0;
        while (o_aidone !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check(name, k, 66);
    endtask

    task automatic quiet_window(input string name, input int cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (o_aidone === 1'b1) seen = 1;
        end
        check(name, seen, 0);
    endtask

    logic [127:0] exp_b;

    initial begin
        rst = 1'b1; mode = '0; start = 0; surrender = 0; prestep = 0;
        row = '0; col = '0; player_done = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("reset_state", o_state, 0);
        check("reset_board", o_board, 0);
        check("reset_rowcol", {o_row, o_col}, 0);

        // Mode 1: opening move, then a tie resolved by lowest index
        pulse_start(2'd1);
        check("start_state", o_state, 1);
        wait_aidone("m1_latency_first");
        check("m1_first_row", o_row, 3);
        check("m1_first_col", o_col, 3);
        check("m1_first_cell", o_board[54 +: 2], 2'b01);
        player(3, 4);
        check("m1_player_cell", o_board[56 +: 2], 2'b10);
        wait_aidone("m1_latency_second");
        check("m1_second_row", o_row, 2);
        check("m1_second_col", o_col, 3);

        pulse_prestep();
`ifdef CTRL_UNDO_EN
        exp_b = '0;
        exp_b[54 +: 2] = 2'b01;
        check("undo_board", o_board, exp_b);
        check("undo_state", o_state, 3);
        pulse_prestep();
        check("undo_twice_board", o_board, exp_b);
`else
        exp_b = '0;
        exp_b[54 +: 2] = 2'b01;
        exp_b[56 +: 2] = 2'b10;
        exp_b[38 +: 2] = 2'b01;
        check("prestep_ignored", o_board, exp_b);
`endif

        // Mode 0: occupied cell ignored, easy picks first empty, surrender mid-scan
        pulse_start(2'd0);
        wait_aidone("m0_latency_first");
        player(3, 3);
        quiet_window("m0_occupied_no_aidone", 80);
        check("m0_occupied_state", o_state, 3);
        player(0, 0);
        wait_aidone("m0_latency_second");
        check("m0_easy_pick", {o_row, o_col}, 6'd1);
        player(7, 7);
        repeat (10) tick();
        surrender = 1'b1;
        tick();
        surrender = 1'b0;
        check("surrender_state", o_state, 4);
        exp_b = '0;
        exp_b[54 +: 2]  = 2'b01;
        exp_b[0 +: 2]   = 2'b10;
        exp_b[2 +: 2]   = 2'b01;
        exp_b[126 +: 2] = 2'b10;
        check("surrender_board", o_board, exp_b);
        quiet_window("surrender_no_aidone", 80);
        player(5, 5);
        check("gameover_ignores_player", o_board, exp_b);

        // Mode 2: hard weights human neighbours double
        pulse_start(2'd2);
        wait_aidone("m2_latency_first");
        player(5, 5);
        wait_aidone("m2_latency_second");
        check("m2_hard_pick", {o_row, o_col}, {3'd4, 3'd4});
        player(4, 3);
        wait_aidone("m2_latency_third");

        // Mode 3: hot-seat colours alternate, then asynchronous reset mid-game
        pulse_start(2'd3);
        check("m3_state", o_state, 3);
        player(0, 0);
        check("m3_first_cell", o_board[0 +: 2], 2'b01);
        player(0, 1);
        check("m3_second_cell", o_board[2 +: 2], 2'b10);
`ifdef CTRL_UNDO_EN
        pulse_prestep();
        check("m3_undo_cell", o_board[2 +: 2], 2'b00);
        player(0, 1);
        check("m3_redo_cell", o_board[2 +: 2], 2'b10);
`endif
        quiet_window("m3_no_aidone", 5);
        rst = 1'b1;
        #2;
        check("midreset_state", o_state, 0);
        check("midreset_board", o_board, 0);
        check("midreset_rowcol", {o_row, o_col}, 0);
        check("midreset_aidone", o_aidone, 0);
        tick();
        rst = 1'b0;
        tick();

        // Mode 3: fill the whole board
        pulse_start(2'd3);
        for (int i = 0; i < 64; i++) player(i / 8, i % 8);
        check("m3_full_state", o_state, 4);

        // Mode 0: fill with human taking the highest free cell; human fills last
        pulse_start(2'd0);
        wait_aidone("fill_latency_first");
        for (int r = 0; r < 40 && m_state == 3; r++) begin
            int pick;
            pick = 0;
            for (int i = 63; i >= 0; i--)
                if (m_board[i] == 2'b00) begin pick = i; break; end
            player(pick / 8, pick % 8);
            if (m_state == 1) wait_aidone("fill_latency");
        end
        check("fill_final_state", o_state, 4);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
